regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Write-back consumer for the MEM/WB pipeline register. It holds eight 16-bit general registers and offers two synchronous read ports that bypass a same-cycle write-back. A per-register busy scoreboard marks registers with an in-flight producer and raises a decode-stage stall when either source operand is still pending. The block sits between the MEM/WB register, which drives its write side, and the ID stage, which drives the read and issue sides.

## Interface
- No parameters; fixed at 8 registers x 16 bits, 3-bit register addresses.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- w1_reg_MEM_WB  in  3  write-back destination register
- reg_en_MEM_WB  in  1  write-back enable
- writedata_MEM_WB  in  16  write-back data
- rd_en  in  1  capture a read on this edge
- rs_reg  in  3  read port A address
- rt_reg  in  3  read port B address
- iss_en  in  1  issue of an instruction that will write a register
- iss_reg  in  3  destination register of the issuing instruction
- rs_data  out  16  port A data, registered
- rt_data  out  16  port B data, registered
- rd_valid  out  1  rs_data/rt_data updated by last edge
- stall  out  1  combinational: a source register is busy
- busy  out  8  scoreboard bits, bit i = register i pending

## Operation
- Write: on an edge with reg_en_MEM_WB=1, register[w1_reg_MEM_WB] <= writedata_MEM_WB. R0 is an ordinary writable register.
- Read: on an edge with rd_en=1, rs_data <= value(rs_reg) and rt_data <= value(rt_reg).
  - value(x) = writedata_MEM_WB if reg_en_MEM_WB=1 and w1_reg_MEM_WB==x; otherwise register[x].
- When rd_en=0, rs_data and rt_data hold their values.
- rd_valid <= rd_en each edge.
- Scoreboard update each edge, evaluated in this order:
  - Clear: if reg_en_MEM_WB=1, busy[w1_reg_MEM_WB] <= 0.
  - Set: if iss_en=1, busy[iss_reg] <= 1.
  - If both name the same register, set wins, because the new producer is younger.
- stall = rd_en & ((busy[rs_reg] & ~clr(rs_reg)) | (busy[rt_reg] & ~clr(rt_reg))).
  - clr(x) = reg_en_MEM_WB & (w1_reg_MEM_WB==x).
  - A write-back arriving this cycle therefore resolves the hazard with no extra bubble.
- Issue while stall=1 is illegal; the upstream stage must hold iss_en=0. This is a bench assertion.
- A second issue to an already-busy register is legal and leaves its bit at 1.

## Timing
- Reset (rst=0, asynchronous): all registers = 16'h0000, rs_data = rt_data = 0, rd_valid = 0, busy = 8'h00.
  - Reset asserted mid-operation clears all state immediately, without waiting for clk.
  - After rst deasserts, the first edge behaves normally.
- Read latency: 1 cycle from the rd_en edge to data on rs_data/rt_data, with rd_valid=1 in that same cycle.
- Write latency: 1 cycle. Data is visible to a same-edge read through the bypass, and to later reads from storage.
- Busy bit: set on the issue edge and visible on busy and stall the next cycle. It clears on the write-back edge, and stall drops combinationally during the write-back cycle itself.
- rs_reg==rt_reg: both ports return identical data.
- Back-to-back rd_en every cycle is supported at full throughput.

## Test plan
- Reset: drive rst=0 mid-stream after writes → all reads return 0, busy=8'h00, rd_valid=0 before the next clk.
- Write then read: write R3=16'hBEEF; next cycle rd_en with rs=3, rt=0 → rs_data=16'hBEEF, rt_data=0, rd_valid=1.
- Bypass: in the same cycle write R5=16'h1234 and read rs=5, rt=5 → both outputs equal 16'h1234 after the edge. The bench also checks that a read of R5 on a cycle without a write gives the stored 1234.
- Scoreboard hazard:
  - Issue to R2 → busy=8'h04.
  - rd_en with rs=2 → stall=1.
  - Write-back of R2=16'h0042 in a later cycle → stall=0 in that cycle, read data = 16'h0042, busy=0 afterwards.
- Simultaneous set and clear: iss_reg=4 and a write-back to R4 on the same edge → busy[4]=1 afterwards.
- Randomized: 2000 cycles of random writes, reads and legal issues compared against a reference model; the stall-issue assertion must never fire.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the write-back, read and issue signals of the register file
// with its busy scoreboard. The ID/WB side uses master, the register file
// uses slave.
interface regfile_scoreboard_if;
    logic [2:0]  w1_reg_MEM_WB;
    logic        reg_en_MEM_WB;
    logic [15:0] writedata_MEM_WB;
    logic        rd_en;
    logic [2:0]  rs_reg;
    logic [2:0]  rt_reg;
    logic        iss_en;
    logic [2:0]  iss_reg;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        rd_valid;
    logic        stall;
    logic [7:0]  busy;

    modport master (
        output w1_reg_MEM_WB, reg_en_MEM_WB, writedata_MEM_WB,
        output rd_en, rs_reg, rt_reg, iss_en, iss_reg,
        input  rs_data, rt_data, rd_valid, stall, busy
    );

    modport slave (
        input  w1_reg_MEM_WB, reg_en_MEM_WB, writedata_MEM_WB,
        input  rd_en, rs_reg, rt_reg, iss_en, iss_reg,
        output rs_data, rt_data, rd_valid, stall, busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Eight 16-bit registers with two registered read ports that bypass a
// same-cycle write-back, plus a per-register busy scoreboard that raises a
// combinational decode stall while a source operand is still in flight.
module regfile_scoreboard (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);

    logic [15:0] r_regs [0:7];
    logic [15:0] r_rs_data;
    logic [15:0] r_rt_data;
    logic        r_rd_valid;
    logic [7:0]  r_busy;

    logic        w_clr_rs;
    logic        w_clr_rt;
    logic [15:0] w_rs_val;
    logic [15:0] w_rt_val;
    logic        w_stall;
    logic [7:0]  w_clr_mask;
    logic [7:0]  w_set_mask;
    logic [7:0]  w_busy_nxt;

    // True when the write-back of this cycle targets register x.
    function automatic logic wb_hit(input logic en, input logic [2:0] wreg,
                                    input logic [2:0] x);
        return en && (wreg == x);
    endfunction

    // Bypassed read values, hazard detection and next scoreboard state.
    always_comb begin
        w_clr_rs   = wb_hit(bus.reg_en_MEM_WB, bus.w1_reg_MEM_WB, bus.rs_reg);
        w_clr_rt   = wb_hit(bus.reg_en_MEM_WB, bus.w1_reg_MEM_WB, bus.rt_reg);
        w_rs_val   = w_clr_rs ? bus.writedata_MEM_WB : r_regs[bus.rs_reg];
        w_rt_val   = w_clr_rt ? bus.writedata_MEM_WB : r_regs[bus.rt_reg];
        // A write-back landing this cycle already resolves the hazard.
        w_stall    = bus.rd_en & ((r_busy[bus.rs_reg] & ~w_clr_rs) |
                                  (r_busy[bus.rt_reg] & ~w_clr_rt));
        w_clr_mask = bus.reg_en_MEM_WB ? (8'b0000_0001 << bus.w1_reg_MEM_WB) : 8'h00;
        w_set_mask = bus.iss_en ? (8'b0000_0001 << bus.iss_reg) : 8'h00;
        // Set is applied after clear so a younger producer keeps the bit.
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // Register storage written from the MEM/WB stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (bus.reg_en_MEM_WB) begin
            r_regs[bus.w1_reg_MEM_WB] <= bus.writedata_MEM_WB;
        end else begin
            r_regs[bus.w1_reg_MEM_WB] <= r_regs[bus.w1_reg_MEM_WB];
        end
    end

    // Registered read ports; data holds when no read is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs_data  <= 16'h0000;
            r_rt_data  <= 16'h0000;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rs_data <= w_rs_val;
                r_rt_data <= w_rt_val;
            end else begin
                r_rs_data <= r_rs_data;
                r_rt_data <= r_rt_data;
            end
        end
    end

    // Busy scoreboard: bit i marks an in-flight producer of register i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 8'h00;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.rs_data  = r_rs_data;
    assign bus.rt_data  = r_rt_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = r_busy;
    assign bus.stall    = w_stall;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// randomized traffic, with read results checked by a queue-based monitor.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
    } rd_exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    rd_exp_t     exp_q[$];
    rd_exp_t     mon_e;
    logic [15:0] m_regs [8];
    logic [7:0]  m_busy;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_val(input logic [2:0] x);
        if (bus.reg_en_MEM_WB && bus.w1_reg_MEM_WB == x) return bus.writedata_MEM_WB;
        return m_regs[x];
    endfunction

    function automatic logic model_stall(input logic rd, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic we,
                                         input logic [2:0] wr);
        logic pend_rs;
        logic pend_rt;
        pend_rs = m_busy[rs] && !(we && wr == rs);
        pend_rt = m_busy[rt] && !(we && wr == rt);
        return rd && (pend_rs || pend_rt);
    endfunction

    task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                         input logic rd, input logic [2:0] rs, input logic [2:0] rt,
                         input logic iss, input logic [2:0] ir);
        bus.reg_en_MEM_WB    = we;
        bus.w1_reg_MEM_WB    = wr;
        bus.writedata_MEM_WB = wd;
        bus.rd_en            = rd;
        bus.rs_reg           = rs;
        bus.rt_reg           = rt;
        bus.iss_en           = iss;
        bus.iss_reg          = ir;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_busy = 8'h00;
        exp_q.delete();
    endtask

    // One clock: check combinational outputs, queue expected read, advance model.
    task automatic step();
        logic    exp_stall;
        rd_exp_t e;
        exp_stall = model_stall(bus.rd_en, bus.rs_reg, bus.rt_reg,
                                bus.reg_en_MEM_WB, bus.w1_reg_MEM_WB);
        #2;
        check("stall", {15'd0, bus.stall}, {15'd0, exp_stall});
        check("busy", {8'd0, bus.busy}, {8'd0, m_busy});
        if (bus.iss_en) check("issue_while_stall", {15'd0, bus.stall}, 16'd0);
        if (bus.rd_en) begin
            e.rs = model_val(bus.rs_reg);
            e.rt = model_val(bus.rt_reg);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (bus.reg_en_MEM_WB) begin
            m_regs[bus.w1_reg_MEM_WB] = bus.writedata_MEM_WB;
            m_busy[bus.w1_reg_MEM_WB] = 1'b0;
        end
        if (bus.iss_en) m_busy[bus.iss_reg] = 1'b1;
        #1;
    endtask

    // Monitor: every cycle with rd_valid must match the oldest queued read.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_valid_unexpected", {15'd0, bus.rd_valid}, 16'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rs_data", bus.rs_data, mon_e.rs);
                check("rt_data", bus.rt_data, mon_e.rt);
            end
        end
    end

    initial begin
        logic we, rd, iss;
        logic [2:0] wr, rs, rt, ir;
        logic [15:0] wd;

        rst = 1'b0;
        model_reset();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_rs_data", bus.rs_data, 16'h0000);
        check("reset_rt_data", bus.rt_data, 16'h0000);
        check("reset_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
        check("reset_busy", {8'd0, bus.busy}, 16'h0000);
        rst = 1'b1;

        // Write then read.
        drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0);
        step();
        check("wr_rd_rs", bus.rs_data, 16'hBEEF);
        check("wr_rd_rt", bus.rt_data, 16'h0000);
        check("wr_rd_valid", {15'd0, bus.rd_valid}, 16'd1);

        // Same-cycle bypass, then stored value.
        drive(1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd5, 1'b0, 3'd0);
        step();
        check("bypass_rs", bus.rs_data, 16'h1234);
        check("bypass_rt", bus.rt_data, 16'h1234);
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3, 1'b0, 3'd0);
        step();
        check("stored_rs", bus.rs_data, 16'h1234);
        check("stored_rt", bus.rt_data, 16'hBEEF);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        step();
        check("hold_rs", bus.rs_data, 16'h1234);
        check("idle_valid", {15'd0, bus.rd_valid}, 16'd0);

        // Scoreboard hazard on R2.
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2);
        step();
        check("busy_r2", {8'd0, bus.busy}, 16'h0004);
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0);
        #1;
        check("hazard_stall", {15'd0, bus.stall}, 16'd1);
        step();
        drive(1'b1, 3'd2, 16'h0042, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0);
        #1;
        check("wb_stall_drop", {15'd0, bus.stall}, 16'd0);
        step();
        check("wb_read", bus.rs_data, 16'h0042);
        check("busy_clear", {8'd0, bus.busy}, 16'h0000);

        // Simultaneous set and clear of R4: set wins.
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4);
        step();
        drive(1'b1, 3'd4, 16'hAAAA, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4);
        step();
        check("set_wins", {8'd0, bus.busy}, 16'h0010);
        drive(1'b1, 3'd4, 16'h5555, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        step();

        // Asynchronous reset mid-stream.
        drive(1'b1, 3'd6, 16'hCAFE, 1'b1, 3'd3, 3'd5, 1'b1, 3'd1);
        step();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        #5;
        rst = 1'b0;
        #1;
        check("async_rs_data", bus.rs_data, 16'h0000);
        check("async_rt_data", bus.rt_data, 16'h0000);
        check("async_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
        check("async_busy", {8'd0, bus.busy}, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd6, 1'b0, 3'd0);
        step();
        check("post_reset_r3", bus.rs_data, 16'h0000);
        check("post_reset_r6", bus.rt_data, 16'h0000);

        // Randomized traffic with only legal issues.
        for (int n = 0; n < 2000; n++) begin
            we  = ($urandom_range(0, 1) == 1);
            wr  = 3'($urandom_range(0, 7));
            wd  = 16'($urandom());
            rd  = ($urandom_range(0, 3) != 0);
            rs  = 3'($urandom_range(0, 7));
            rt  = 3'($urandom_range(0, 7));
            ir  = 3'($urandom_range(0, 7));
            iss = ($urandom_range(0, 3) == 0) && !model_stall(rd, rs, rt, we, wr);
            drive(we, wr, wd, rd, rs, rt, iss, ir);
            step();
        end

        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        step();
        @(negedge clk);
        #1;
        check("reads_outstanding", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
